// File: rtl/cve2_obi_mem_responder.sv
// OBI-style memory responder: word-addressed SRAM behind a req/gnt/rvalid port
// with programmable grant and response latency and an in-order response FIFO.
// Optional range checking: define CVE2_OBI_RANGE_ERR_EN to grant out-of-range
// accesses with err_o=1 and no array side effects; otherwise addresses wrap.
module cve2_obi_mem_responder #(
    parameter int unsigned MemWords       = 1024,
    parameter logic [31:0] BaseAddr       = 32'h0000_0000,
    parameter int unsigned GntLatency     = 0,
    parameter int unsigned RespLatency    = 1,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int unsigned AW = (MemWords > 1) ? $clog2(MemWords) : 1;
    localparam int unsigned CW = (GntLatency > 0) ? $clog2(GntLatency + 1) : 1;
    localparam int unsigned DW = (RespLatency > 1) ? $clog2(RespLatency) : 1;
    localparam int unsigned PW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned NW = $clog2(MaxOutstanding + 1);

    localparam logic [CW-1:0] GntLat  = CW'(GntLatency);
    localparam logic [DW-1:0] RespCd  = DW'(RespLatency - 1);
    localparam logic [NW-1:0] MaxCnt  = NW'(MaxOutstanding);
    localparam logic [PW-1:0] LastPtr = PW'(MaxOutstanding - 1);

    typedef enum logic {
        IDLE,
        WAIT
    } gnt_state_e;

    typedef struct packed {
        logic [31:0]   rdata;
        logic          err;
        logic [DW-1:0] cd;
    } resp_t;

    gnt_state_e    state, state_d;
    logic [CW-1:0] wait_cnt, wait_cnt_d;
    logic          gnt;
    logic          full;
    logic          hs;

    logic [31:0]   offset;
    logic [AW-1:0] idx;
    logic          wr_en;
    logic [31:0]   rd_word;
    logic [31:0]   new_rdata;
    logic          new_err;
    logic          unused_addr;

    logic [31:0]   mem [MemWords];

    resp_t         fifo [MaxOutstanding];
    logic [PW-1:0] head, tail;
    logic [NW-1:0] count;
    logic          pop;

    // Full is judged on the current count; a same-cycle pop frees nothing yet.
    assign full = (count == MaxCnt);

    // Grant FSM: count held-request cycles up to GntLatency, stall while full.
    always_comb begin
        state_d    = state;
        wait_cnt_d = wait_cnt;
        gnt        = 1'b0;
        case (state)
            IDLE: begin
                if (req_i && !full) begin
                    if (GntLatency == 0) begin
                        gnt = 1'b1;
                    end else begin
                        state_d    = WAIT;
                        wait_cnt_d = CW'(1);
                    end
                end
            end
            WAIT: begin
                if (!req_i) begin
                    // Initiator withdrew the request: tolerated, restart later.
                    state_d    = IDLE;
                    wait_cnt_d = '0;
                end else begin
                    gnt = (wait_cnt == GntLat) && !full;
                    if (gnt) begin
                        state_d    = IDLE;
                        wait_cnt_d = '0;
                    end else if (wait_cnt != GntLat) begin
                        wait_cnt_d = wait_cnt + CW'(1);
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Grant FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_d;
            wait_cnt <= wait_cnt_d;
        end
    end

    assign gnt_o = gnt & rst_ni;
    assign hs    = req_i & gnt_o;

    // Word index from the base-relative offset; wraps modulo the array size.
    assign offset      = addr_i - BaseAddr;
    assign idx         = offset[AW+1:2];
    assign unused_addr = ^{offset[1:0], offset[31:AW+2]};
    assign rd_word     = mem[idx];

`ifdef CVE2_OBI_RANGE_ERR_EN
    logic in_range;
    // Out-of-range accesses are granted but touch nothing and report err.
    assign in_range  = ({1'b0, offset} < (33'(MemWords) * 33'd4));
    assign wr_en     = hs & we_i & in_range;
    assign new_rdata = (we_i || !in_range) ? 32'h0 : rd_word;
    assign new_err   = ~in_range;
`else
    assign wr_en     = hs & we_i;
    assign new_rdata = we_i ? 32'h0 : rd_word;
    assign new_err   = 1'b0;
`endif

    // Byte-enabled array write; contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) mem[idx][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    // Head retires when its countdown has reached zero.
    assign pop = (count != '0) && (fifo[head].cd == '0);

    // Response FIFO: age all entries, push on handshake, pop mature head.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < MaxOutstanding; i++) fifo[i] <= '0;
        end else begin
            for (int i = 0; i < MaxOutstanding; i++) begin
                if (fifo[i].cd != '0) fifo[i].cd <= fifo[i].cd - DW'(1);
            end
            if (hs) begin
                fifo[tail] <= '{rdata: new_rdata, err: new_err, cd: RespCd};
                tail       <= (tail == LastPtr) ? '0 : tail + PW'(1);
            end
            if (pop) head <= (head == LastPtr) ? '0 : head + PW'(1);
            case ({hs, pop})
                2'b10:   count <= count + NW'(1);
                2'b01:   count <= count - NW'(1);
                default: count <= count;
            endcase
        end
    end

    assign rvalid_o = pop;
    assign rdata_o  = pop ? fifo[head].rdata : 32'h0;
    assign err_o    = pop ? fifo[head].err : 1'b0;

endmodule
